axi_lite_sram: RTL
==================

AXI_LITE_SRAM -- requirements
Module: axi_lite_sram

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning the number of 32-bit memory words.
REQ-002 SHALL have parameter BASE, default 32'h8000_0000, meaning the byte address of word 0.
REQ-003 SHALL have parameter LAT_MASK, default 4'hF, meaning the mask applied to LFSR bits for the extra wait cycles (0 gives fixed latency).
REQ-004 SHALL have parameter SEED, default 16'hACE1, meaning the LFSR reset value, which must be nonzero.
REQ-005 SHALL define the ports as follows; the reset is rst, synchronous, active-high, and the clock is clk:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- araddr  in  32  read byte address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data accepted
- awaddr  in  32  write byte address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response accepted

Function
REQ-006 SHALL run independent read and write FSMs, each with states IDLE, DELAY and RESP, and one outstanding transaction per channel.
REQ-007 SHALL drive arready=1 only in read IDLE; an AR handshake (arvalid&&arready) SHALL latch araddr and load cnt=lfsr[3:0]&LAT_MASK.
REQ-008 SHALL, from IDLE after a handshake, go to RESP if cnt==0, else to DELAY; DELAY SHALL decrement cnt and go to RESP on the cycle cnt==1.
REQ-009 SHALL register rdata and rresp on entry to RESP; rvalid=1 in RESP; with LAT_MASK=0, an AR handshake at edge N gives rvalid=1 from edge N+1.
REQ-010 SHALL hold rdata, rresp and rvalid stable in RESP until rready; an R handshake SHALL return to IDLE, with rvalid=0 next cycle and no back-to-back AR acceptance in that same cycle.
REQ-011 SHALL form the word index as (addr-BASE)>>2 and ignore addr[1:0]; any address outside [BASE, BASE+4*DEPTH) SHALL give resp=2'b10 (SLVERR) and rdata=0, otherwise 2'b00.
REQ-012 SHALL drive awready=1 in write IDLE until AW is captured, and wready=1 in write IDLE until W is captured; AW and W may arrive in either order or in the same cycle.
REQ-013 SHALL, once both AW and W are captured, load cnt=(lfsr[7:4]&LAT_MASK) and proceed as in REQ-008.
REQ-014 SHALL, on entry to write RESP, commit the bytes selected by wstrb; wstrb=0 or an out-of-range address SHALL leave memory unchanged, with an out-of-range address giving bresp=SLVERR.
REQ-015 SHALL hold bvalid=1 in write RESP until bready, then return to IDLE.
REQ-016 SHALL, for a read sample and a write commit to the same word at the same edge, return the pre-write data to the read.
REQ-017 SHALL advance a 16-bit Galois LFSR (taps 16,14,13,11) every cycle, shared by both channels.

Reset
REQ-018 SHALL, on rst, put both FSMs in IDLE, set arready=awready=wready=1, rvalid=bvalid=0, rdata=0, rresp=bresp=0, lfsr=SEED, and clear the captured flags.
REQ-019 SHALL abort any in-flight transaction on a mid-operation rst with no response issued; memory contents SHALL be preserved and a write not yet committed SHALL be dropped.

Structure
REQ-020 SHALL take the RESP_OKAY/RESP_SLVERR constants and the state enum (S_IDLE, S_DELAY, S_RESP) from shared package npc_axi_pkg, also used by IFU/LSU masters.
REQ-021 SHALL implement the LFSR as sub-module lfsr16 (clk, rst, seed, out[15:0]).

Verification
REQ-022 SHALL verify: with LAT_MASK=0, write 0xDEADBEEF to 0x80000010 with wstrb=F, then read 0x80000010 -> bvalid 1 cycle after the W/AW handshake, then rdata=0xDEADBEEF, rresp=0.
REQ-023 SHALL verify: over word 0x11223344, write wdata=0xAABBCCDD with wstrb=4'b0101 -> a read returns 0x11BB33DD.
REQ-024 SHALL verify: read address 0x7FFFFFFC and BASE+4*DEPTH -> rresp=2'b10, rdata=0, and memory unchanged after a write to the same addresses.
REQ-025 SHALL verify: hold rready=0 for 5 cycles in RESP -> rvalid and rdata stable, arready=0 throughout, one response only.
REQ-026 SHALL verify: W presented 3 cycles before AW -> wready drops after the W handshake, and the write completes only after AW.
REQ-027 SHALL verify: with LAT_MASK=F, assert rst in read DELAY -> next cycle rvalid=0, arready=1, and a following read of a written word returns the old data.

Source files
------------

// File: rtl/npc_axi_pkg.sv
// npc_axi_pkg: AXI response codes and channel FSM states shared by the SRAM slave and the IFU/LSU masters
package npc_axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RESP} state_t;
endpackage

// File: rtl/axi_lite_sram_lfsr16.sv
// lfsr16: 16-bit Galois LFSR (taps 16,14,13,11) advancing every cycle
//   clk, rst: clock and sync active-high reset; seed: reset value (nonzero); out: current state
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] out
);
  always_ff @(posedge clk)
    out <= rst ? seed : ({1'b0, out[15:1]} ^ (out[0] ? 16'hB400 : 16'h0000));
endmodule

// File: rtl/axi_lite_sram.sv
// axi_lite_sram: AXI4-Lite SRAM slave with LFSR-randomised response latency
//   clk, rst: clock and sync active-high reset
//   ar*/r*: read address and read data channels; aw*/w*/b*: write address, data and response channels
module axi_lite_sram
  import npc_axi_pkg::*;
#(
  parameter int          DEPTH    = 4096,
  parameter logic [31:0] BASE     = 32'h8000_0000,
  parameter logic [3:0]  LAT_MASK = 4'hF,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  logic [31:0] r_mem [DEPTH];
  logic [15:0] w_lfsr;
  logic        w_unused;
  state_t      r_rs, w_rs_next, r_ws, w_ws_next;
  logic [3:0]  r_rcnt, w_rcnt_next, r_wcnt, w_wcnt_next, r_wstrb, w_ws;
  logic [31:0] r_araddr, r_awaddr, r_wdata, r_rdata;
  logic [31:0] w_raddr, w_roff, w_waddr, w_woff, w_wd;
  logic [1:0]  r_rresp, r_bresp;
  logic        r_aw_got, r_w_got, w_rload, w_commit, w_rok, w_wok, w_aw_hs, w_w_hs;
  logic [AW-1:0] w_ridx, w_widx;

  lfsr16 u_lfsr (.clk(clk), .rst(rst), .seed(SEED), .out(w_lfsr));
  assign w_unused = ^w_lfsr[15:8];

  // In IDLE the address is used straight off the bus so a zero-wait access completes on the handshake edge
  assign w_raddr = (r_rs == S_IDLE) ? araddr : r_araddr;
  assign w_roff  = w_raddr - BASE;
  assign w_rok   = w_roff < SPAN;
  assign w_ridx  = w_roff[AW+1:2];
  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_waddr = r_aw_got ? r_awaddr : awaddr;
  assign w_wd    = r_w_got ? r_wdata : wdata;
  assign w_ws    = r_w_got ? r_wstrb : wstrb;
  assign w_woff  = w_waddr - BASE;
  assign w_wok   = w_woff < SPAN;
  assign w_widx  = w_woff[AW+1:2];

  assign arready = r_rs == S_IDLE;
  assign rvalid  = r_rs == S_RESP;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign awready = (r_ws == S_IDLE) && !r_aw_got;
  assign wready  = (r_ws == S_IDLE) && !r_w_got;
  assign bvalid  = r_ws == S_RESP;
  assign bresp   = r_bresp;

  always_ff @(posedge clk) begin
    r_rs   <= rst ? S_IDLE : w_rs_next;
    r_ws   <= rst ? S_IDLE : w_ws_next;
    r_rcnt <= w_rcnt_next;
    r_wcnt <= w_wcnt_next;
  end

  always_comb begin
    w_rs_next   = r_rs;
    w_rcnt_next = r_rcnt;
    w_rload     = 1'b0;
    case (r_rs)
      S_IDLE: if (arvalid) begin
        w_rcnt_next = w_lfsr[3:0] & LAT_MASK;
        w_rload     = w_rcnt_next == 4'd0;
        w_rs_next   = w_rload ? S_RESP : S_DELAY;
      end
      S_DELAY: begin
        w_rcnt_next = r_rcnt - 4'd1;
        w_rload     = r_rcnt == 4'd1;
        w_rs_next   = w_rload ? S_RESP : S_DELAY;
      end
      S_RESP:  w_rs_next = rready ? S_IDLE : S_RESP;
      default: w_rs_next = S_IDLE;
    endcase
  end

  // Address and data may each have been captured earlier or be arriving this cycle
  always_comb begin
    w_ws_next   = r_ws;
    w_wcnt_next = r_wcnt;
    w_commit    = 1'b0;
    case (r_ws)
      S_IDLE: if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) begin
        w_wcnt_next = w_lfsr[7:4] & LAT_MASK;
        w_commit    = w_wcnt_next == 4'd0;
        w_ws_next   = w_commit ? S_RESP : S_DELAY;
      end
      S_DELAY: begin
        w_wcnt_next = r_wcnt - 4'd1;
        w_commit    = r_wcnt == 4'd1;
        w_ws_next   = w_commit ? S_RESP : S_DELAY;
      end
      S_RESP:  w_ws_next = bready ? S_IDLE : S_RESP;
      default: w_ws_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_bresp  <= RESP_OKAY;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
    end else begin
      if (arvalid && arready) r_araddr <= araddr;
      if (w_rload) begin
        r_rdata <= w_rok ? r_mem[w_ridx] : '0;
        r_rresp <= w_rok ? RESP_OKAY : RESP_SLVERR;
      end
      if (w_aw_hs) begin
        r_awaddr <= awaddr;
        r_aw_got <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
        r_w_got <= 1'b1;
      end
      if (bvalid && bready) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
      end
      if (w_commit) r_bresp <= w_wok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Memory is never reset; a concurrent read sees the pre-write word through NBA ordering
  always_ff @(posedge clk)
    if (!rst && w_commit && w_wok)
      for (int i = 0; i < 4; i++)
        if (w_ws[i]) r_mem[w_widx][8*i +: 8] <= w_wd[8*i +: 8];
endmodule
